// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states and the default byte width / launch timeout
// used by the transmitter, the arbiter and the UART top level.
package uart_pkg;

  localparam int UART_DATA_W         = 8;
  localparam int UART_LAUNCH_TIMEOUT = 4096;

  typedef enum logic [2:0] {
    IDLE,
    LAUNCH,
    WAIT_BUSY,
    WAIT_DONE,
    FINISH
  } uart_arb_state_e;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Start/data/busy handshake between the arbiter (master) and the UART transmitter (slave).
interface uart_tx_arbiter_if
  import uart_pkg::*;
#(
  parameter int DATA_W = UART_DATA_W
) ();

  logic              tx_start;
  logic [DATA_W-1:0] tx_data;
  logic              tx_busy;

  modport master (output tx_start, output tx_data, input tx_busy);
  modport slave  (input tx_start, input tx_data, output tx_busy);

endinterface

// File: rtl/uart_tx_arbiter_rr.sv
// Combinational round-robin pick: first set request at or above ptr, wrapping around.
module rr_arbiter #(
  parameter int NUM_REQ = 4
) (
  input  logic [NUM_REQ-1:0]         req,
  input  logic [$clog2(NUM_REQ)-1:0] ptr,
  output logic [NUM_REQ-1:0]         gnt,
  output logic [$clog2(NUM_REQ)-1:0] idx,
  output logic                       valid
);

  localparam int IDX_W = $clog2(NUM_REQ);

  always_comb begin : pick
    int j;
    gnt   = '0;
    idx   = '0;
    valid = 1'b0;
    j     = 0;
    for (int i = 0; i < NUM_REQ; i++) begin
      j = (int'(ptr) + i) % NUM_REQ;
      if (!valid && req[j]) begin
        valid  = 1'b1;
        idx    = IDX_W'(j);
        gnt[j] = 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin sharing of one UART transmitter among NUM_REQ byte producers; every output
// is registered so the transmitter and clients see glitch-free, one-hot handshakes.
module uart_tx_arbiter
  import uart_pkg::*;
#(
  parameter int NUM_REQ        = 4,
  parameter int DATA_W         = UART_DATA_W,
  parameter int LAUNCH_TIMEOUT = UART_LAUNCH_TIMEOUT
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req,
  input  logic [NUM_REQ*DATA_W-1:0] req_data,
  output logic [NUM_REQ-1:0]        gnt,
  output logic [NUM_REQ-1:0]        done,
  output logic [NUM_REQ-1:0]        err,
  output logic                      idle,
  uart_tx_arbiter_if.master         tx_if
);

  localparam int IDX_W = $clog2(NUM_REQ);
  localparam int CNT_W = $clog2(LAUNCH_TIMEOUT) + 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(LAUNCH_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = '1;

  uart_arb_state_e     state_q, state_d;
  logic [NUM_REQ-1:0]  gnt_q, gnt_d, done_q, done_d, err_q, err_d;
  logic                start_q, start_d;
  logic [DATA_W-1:0]   data_q, data_d;
  logic [IDX_W-1:0]    idx_q, idx_d, ptr_q, ptr_d, next_ptr;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [NUM_REQ-1:0]  arb_gnt;
  logic [IDX_W-1:0]    arb_idx;
  logic                arb_valid;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr (
    .req   (req),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .idx   (arb_idx),
    .valid (arb_valid)
  );

  assign next_ptr       = (idx_q == IDX_W'(NUM_REQ - 1)) ? '0 : idx_q + IDX_W'(1);
  assign gnt            = gnt_q;
  assign done           = done_q;
  assign err            = err_q;
  assign idle           = (state_q == IDLE);
  assign tx_if.tx_start = start_q;
  assign tx_if.tx_data  = data_q;

  always_comb begin
    state_d = state_q;
    gnt_d   = gnt_q;
    done_d  = '0;
    err_d   = '0;
    start_d = start_q;
    data_d  = data_q;
    idx_d   = idx_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    case (state_q)
      IDLE: begin
        // A busy transmitter here belongs to someone else; leave it alone.
        if (arb_valid && !tx_if.tx_busy) begin
          gnt_d   = arb_gnt;
          idx_d   = arb_idx;
          data_d  = req_data[int'(arb_idx)*DATA_W +: DATA_W];
          state_d = LAUNCH;
        end
      end
      LAUNCH: begin
        start_d = 1'b1;
        cnt_d   = '0;
        state_d = WAIT_BUSY;
      end
      WAIT_BUSY: begin
        if (tx_if.tx_busy) begin
          start_d = 1'b0;
          state_d = WAIT_DONE;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = gnt_q;
          gnt_d   = '0;
          start_d = 1'b0;
          ptr_d   = next_ptr;
          state_d = IDLE;
        end else if (cnt_q != CNT_MAX) begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      WAIT_DONE: begin
        if (!tx_if.tx_busy) begin
          done_d  = gnt_q;
          gnt_d   = '0;
          state_d = FINISH;
        end
      end
      FINISH: begin
        ptr_d   = next_ptr;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      gnt_q   <= '0;
      done_q  <= '0;
      err_q   <= '0;
      start_q <= 1'b0;
      data_q  <= '0;
      idx_q   <= '0;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      gnt_q   <= gnt_d;
      done_q  <= done_d;
      err_q   <= err_d;
      start_q <= start_d;
      data_q  <= data_d;
      idx_q   <= idx_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule
